// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Integer clocks per bit; both the receiver and the transmitter use this divisor.
  function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset loads the idle level so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of RXD, one-byte holding register with valid/ready.
//
// state | meaning
// IDLE  | line idle, waiting for rxs to fall
// START | timing to the middle of the start bit to confirm it
// DATA  | sampling data bits LSB-first at mid-bit
// STOP  | sampling the stop bit at mid-bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 1_000_000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_nxt;
  logic [TW-1:0]        timer_q;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en;
  logic                 byte_done;
  logic                 frame_bad;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 accept;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync_rxd (
    .clk(CLK),
    .rst(RESET),
    .d  (RXD),
    .q  (rxs)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the single-cycle strobes that drive the datapath.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (timer_q == T_HALF) state_nxt = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (timer_q == T_FULL) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (timer_q == T_FULL) begin
          if (rxs) begin
            byte_done = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer: restarts on every state change and wraps once per bit period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q <= '0;
    end else if (state_nxt != state || state == IDLE || state == BREAK || timer_q == T_FULL) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + CW'(1);
      shreg   <= {rxs, shreg[DATA_BITS-1:1]};
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end
  end

  assign accept = rx_valid && rx_ready;

  // Holding register: a new byte loads when the slot is empty or being emptied this cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (byte_done && (!rx_valid || rx_ready)) begin
      rx_data  <= shreg;
      rx_valid <= 1'b1;
    end else if (accept) begin
      rx_valid <= 1'b0;
    end
  end

  // Error flags: frame_err is a one-cycle pulse, overrun holds until the next accept.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (accept)                     overrun_q <= 1'b0;
      else if (byte_done && rx_valid) overrun_q <= 1'b1;
    end
  end

  // Flags are masked while RESET is high so they never coincide with it.
  assign frame_err = frame_err_q & ~RESET;
  assign overrun   = overrun_q & ~RESET;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 100 clocks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 100;

  logic       CLK;
  logic       RESET;
  logic       RXD;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int fe_cyc   = 0;
  int valid_rises = 0;
  logic prev_valid = 1'b0;

  uart_rx dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RXD      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Cycle counter for latency measurements.
  always @(posedge CLK) cyc <= cyc + 1;

  // Event monitors sampled mid-cycle.
  always @(negedge CLK) begin
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (rx_valid && !prev_valid) valid_rises <= valid_rises + 1;
    prev_valid <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RXD = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) wait_clk();
    end
    RXD = 1'b1;
    repeat (CPB) wait_clk();
  endtask

  task automatic accept_byte();
    rx_ready = 1'b1;
    wait_clk();
    rx_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc0;
    int fe_base;
    int vr_base;

    RESET = 1'b1;
    RXD = 1'b1;
    rx_ready = 1'b0;
    repeat (3) wait_clk();
    RESET = 1'b0;
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    repeat (10) wait_clk();

    // 1: single byte, latency from start edge to rx_valid
    lat = 0;
    fork
      send_byte(8'h55);
      begin
        while (!rx_valid && lat < 1000) begin
          wait_clk();
          lat++;
        end
      end
    join
    check("t1_latency", 32'(lat), 32'd953);
    check("t1_valid", 32'(rx_valid), 32'd1);
    check("t1_data", 32'(rx_data), 32'h55);
    accept_byte();
    check("t1_valid_clr", 32'(rx_valid), 32'd0);
    check("t1_ferr_cnt", 32'(fe_cnt), 32'd0);
    check("t1_ovr", 32'(overrun), 32'd0);

    // 2: short low glitch is rejected
    vr_base = valid_rises;
    RXD = 1'b0;
    repeat (30) wait_clk();
    RXD = 1'b1;
    repeat (200) wait_clk();
    check("t2_state_idle", 32'(dut.state), 32'(IDLE));
    check("t2_no_valid", 32'(valid_rises - vr_base), 32'd0);
    check("t2_no_ferr", 32'(fe_cnt), 32'd0);

    // 3: line stuck low from reset release gives exactly one frame_err
    fe_base = fe_cnt;
    vr_base = valid_rises;
    RESET = 1'b1;
    RXD = 1'b0;
    repeat (2) wait_clk();
    RESET = 1'b0;
    cyc0 = cyc;
    repeat (1500) wait_clk();
    check("t3_ferr_once", 32'(fe_cnt - fe_base), 32'd1);
    check("t3_ferr_time", 32'(fe_cyc - cyc0), 32'd953);
    check("t3_no_valid", 32'(valid_rises - vr_base), 32'd0);
    check("t3_state_break", 32'(dut.state), 32'(BREAK));
    RXD = 1'b1;
    repeat (20) wait_clk();
    send_byte(8'hA3);
    check("t3_valid", 32'(rx_valid), 32'd1);
    check("t3_data", 32'(rx_data), 32'hA3);
    check("t3_ferr_still_once", 32'(fe_cnt - fe_base), 32'd1);
    accept_byte();
    check("t3_valid_clr", 32'(rx_valid), 32'd0);

    // 4: overrun keeps the first byte
    send_byte(8'h12);
    send_byte(8'h34);
    check("t4_valid", 32'(rx_valid), 32'd1);
    check("t4_data_kept", 32'(rx_data), 32'h12);
    check("t4_ovr_set", 32'(overrun), 32'd1);
    repeat (50) wait_clk();
    check("t4_ovr_sticky", 32'(overrun), 32'd1);
    accept_byte();
    check("t4_valid_clr", 32'(rx_valid), 32'd0);
    check("t4_ovr_clr", 32'(overrun), 32'd0);

    // 5: accept exactly on the second completion cycle
    fork
      begin
        send_byte(8'h12);
        send_byte(8'h34);
      end
      begin
        repeat (1952) wait_clk();
        check("t5_pre_data", 32'(rx_data), 32'h12);
        check("t5_pre_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        wait_clk();
        rx_ready = 1'b0;
        check("t5_data_new", 32'(rx_data), 32'h34);
        check("t5_valid", 32'(rx_valid), 32'd1);
        check("t5_no_ovr", 32'(overrun), 32'd0);
      end
    join
    accept_byte();
    check("t5_valid_clr", 32'(rx_valid), 32'd0);

    // 6: reset during data bit 4 abandons the frame
    vr_base = valid_rises;
    fork
      send_byte(8'hFF);
      begin
        repeat (550) wait_clk();
        RESET = 1'b1;
        wait_clk();
        RESET = 1'b0;
        check("t6_rst_valid", 32'(rx_valid), 32'd0);
        check("t6_rst_data", 32'(rx_data), 32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        check("t6_rst_ovr", 32'(overrun), 32'd0);
        check("t6_rst_state", 32'(dut.state), 32'(IDLE));
      end
    join
    check("t6_no_byte", 32'(valid_rises - vr_base), 32'd0);
    send_byte(8'h0F);
    check("t6_valid", 32'(rx_valid), 32'd1);
    check("t6_data", 32'(rx_data), 32'h0F);
    check("t6_no_ovr", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
